// File: rtl/corescore_stream_arbiter_if.sv
// Stream bundle between the NUM_SRC sources, the arbiter and the UART emitter.
// Signal names are taken from the arbiter's point of view: i_* enter the
// arbiter, o_* leave it.
interface corescore_stream_arbiter_if #(
  parameter int NUM_SRC = 2
);

  logic [8*NUM_SRC-1:0] i_tdata;
  logic [NUM_SRC-1:0]   i_tlast;
  logic [NUM_SRC-1:0]   i_tvalid;
  logic [NUM_SRC-1:0]   o_tready;

  logic [7:0]           o_tdata;
  logic                 o_tlast;
  logic                 o_tvalid;
  logic                 i_tready;

  // Arbiter side: consumes the source beats and the emitter ready.
  modport slave (
    input  i_tdata,
    input  i_tlast,
    input  i_tvalid,
    input  i_tready,
    output o_tready,
    output o_tdata,
    output o_tlast,
    output o_tvalid
  );

  // Environment side: the sources plus the emitter.
  modport master (
    output i_tdata,
    output i_tlast,
    output i_tvalid,
    output i_tready,
    input  o_tready,
    input  o_tdata,
    input  o_tlast,
    input  o_tvalid
  );

endinterface

// File: rtl/corescore_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one byte-wide AXI-Stream emitter
// between NUM_SRC sources. A grant is held from the first beat through the
// tlast handshake, so packets never interleave on the UART line. After a
// packet from source k, source k has the lowest priority next time round.
module corescore_stream_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  corescore_stream_arbiter_if.slave  bus,
  output logic [NUM_SRC-1:0]         o_grant,
  output logic                       o_busy,
  output logic [CNT_W-1:0]           o_pkt_cnt
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [IDX_W:0]   NSRC     = (IDX_W+1)'(NUM_SRC);
  localparam logic [IDX_W-1:0] LAST_SRC = IDX_W'(NUM_SRC - 1);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     gnt_idx;
  logic [IDX_W-1:0]     last_idx;
  logic [CNT_W-1:0]     pkt_cnt;
  logic [NUM_SRC-1:0]   grant_q;
  logic                 busy_q;

  logic [IDX_W:0]       base;
  logic [IDX_W:0]       pick;
  logic [IDX_W:0]       sum;
  logic [2*NUM_SRC-1:0] rot;
  logic                 any_req;
  logic [IDX_W-1:0]     winner;

  logic [7:0]           sel_data;
  logic                 sel_last;
  logic                 sel_valid;
  logic                 hs_last;

  // Round-robin pick: rotate the request vector so the source after
  // last_idx lands at bit 0, take the lowest set bit, then rotate the
  // resulting offset back into a source index (modulo NUM_SRC).
  always_comb begin
    base = {1'b0, last_idx} + (IDX_W+1)'(1);
    if (base >= NSRC) base = '0;
    rot  = {bus.i_tvalid, bus.i_tvalid} >> base;
    pick = '0;
    for (int p = NUM_SRC - 1; p >= 0; p--) begin
      if (rot[p]) pick = (IDX_W+1)'(p);
    end
    sum = base + pick;
    if (sum >= NSRC) sum = sum - NSRC;
    winner  = sum[IDX_W-1:0];
    any_req = |bus.i_tvalid;
  end

  // Zero-latency mux from the granted source to the emitter; everything is
  // forced to zero while idle so the emitter sees a clean bus between packets.
  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (gnt_idx == IDX_W'(s)) begin
        sel_data  = bus.i_tdata[8*s +: 8];
        sel_last  = bus.i_tlast[s];
        sel_valid = bus.i_tvalid[s];
      end
    end
    bus.o_tdata  = '0;
    bus.o_tlast  = 1'b0;
    bus.o_tvalid = 1'b0;
    bus.o_tready = '0;
    if (state == GRANT) begin
      bus.o_tdata  = sel_data;
      bus.o_tlast  = sel_last;
      bus.o_tvalid = sel_valid;
      bus.o_tready = grant_q & {NUM_SRC{bus.i_tready}};
    end
    hs_last = (state == GRANT) && sel_valid && sel_last && bus.i_tready;
  end

  // Grant FSM: arbitrate in IDLE, hold the grant until the tlast handshake,
  // then spend one IDLE cycle before the next arbitration.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      gnt_idx  <= '0;
      last_idx <= LAST_SRC;
      pkt_cnt  <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_idx <= winner;
            grant_q <= NUM_SRC'(1) << winner;
            busy_q  <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (hs_last) begin
            last_idx <= gnt_idx;
            pkt_cnt  <= pkt_cnt + CNT_W'(1);
            grant_q  <= '0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_grant   = grant_q;
  assign o_busy    = busy_q;
  assign o_pkt_cnt = pkt_cnt;

endmodule

// File: doc/corescore_stream_arbiter.md
# corescore_stream_arbiter

Packet-level round-robin arbiter that shares the single byte-wide AXI-Stream UART emitter between NUM_SRC stream sources, e.g. the corescorecore collector plus auxiliary status or heartbeat generators. Sits between the sources and the emitter in the top-level wrapper. A grant is held for a whole packet, from first beat through the `tlast` handshake, so messages are never interleaved on the UART line. Also provides grant/busy status and a completed-packet counter for an LED or debug header.

## Interface

**Parameters**
- `NUM_SRC`, default 2: number of stream sources; legal range 2..8.
- `CNT_W`, default 16: width of the completed-packet counter.

**Ports**
- `i_clk` (in, 1): system clock; all logic is on the rising edge.
- `i_rst` (in, 1): reset; synchronous and active-high.
- `i_tdata` (in, 8*NUM_SRC): source data; byte n is at [8n+7:8n].
- `i_tlast` (in, NUM_SRC): per-source last beat of packet.
- `i_tvalid` (in, NUM_SRC): per-source beat valid.
- `o_tready` (out, NUM_SRC): per-source ready.
- `o_tdata` (out, 8): data to the emitter.
- `o_tlast` (out, 1): last beat to the emitter.
- `o_tvalid` (out, 1): valid to the emitter.
- `i_tready` (in, 1): ready from the emitter.
- `o_grant` (out, NUM_SRC): one-hot current grant; all zero when idle.
- `o_busy` (out, 1): high while a packet is granted.
- `o_pkt_cnt` (out, CNT_W): number of completed packets; wraps modulo 2^CNT_W.

## Operation

**State machine**
- Two states, `IDLE` and `GRANT`.
- Registers: `state`, `gnt_idx` (clog2(NUM_SRC) bits), `last_idx`, `pkt_cnt`.

**IDLE**
- `o_tvalid`=0, all `o_tready`=0, `o_grant`=0, `o_busy`=0.
- If any `i_tvalid` bit is set, pick the first requester scanning upward from `last_idx+1`, wrapping modulo NUM_SRC.
- Load `gnt_idx` with the winner and go to `GRANT`.
- If no request is present, stay in `IDLE`.

**GRANT**
- `o_tdata`/`o_tlast`/`o_tvalid` are driven combinationally from source `gnt_idx`.
- `o_tready[gnt_idx]` = `i_tready`; all other `o_tready` bits are 0.
- `o_grant` = one-hot(`gnt_idx`); `o_busy`=1.
- On `o_tvalid & i_tready & o_tlast`:
  - `last_idx` <= `gnt_idx`
  - `pkt_cnt` <= `pkt_cnt`+1
  - next state is `IDLE`.
- Otherwise stay in `GRANT`.

**Grant hold**
- The grant never changes mid-packet, regardless of other requests.
- If the granted source drops `tvalid` mid-packet, the grant is still held and `o_tvalid` follows the source.

**Fairness**
- Round-robin pointer is `last_idx`.
- After a packet from source k completes, source k has the lowest priority at the next arbitration.

**Single-beat packets**
- `tlast` on the first beat is legal: grant, one transfer, return to `IDLE`.

**Reset**
- Values: `state`=`IDLE`, `gnt_idx`=0, `last_idx`=NUM_SRC-1 (so source 0 wins first), `pkt_cnt`=0.
- All outputs are low/zero the cycle after reset is sampled.
- Reset mid-packet aborts the grant immediately; the partial packet is not counted.

**Counter**
- `pkt_cnt` is unsigned and wraps from 2^CNT_W-1 to 0.

## Timing

- **Arbitration latency:** one cycle. `i_tvalid[n]` high in `IDLE` at cycle t gives `o_tvalid`=1 and `o_grant[n]`=1 at cycle t+1.
- **Data path:** combinational mux with zero latency; the `o_tready`→source path is combinational from `i_tready`.
- **Inter-packet gap:** minimum one cycle. A `tlast` handshake at cycle k gives `IDLE` at k+1 and the next grant at k+2, even if requests are pending. The emitter is far slower, so no throughput is lost.
- **Counter update:** `o_pkt_cnt` increments in the cycle after the `tlast` handshake.
- **Output reset values:**
  - `o_tvalid`=0, `o_tready`=0, `o_tlast`=0, `o_tdata`=0, `o_grant`=0, `o_busy`=0, `o_pkt_cnt`=0.
  - `o_tdata`/`o_tlast` are forced to 0 in `IDLE`.
- **Simultaneous events:**
  - A new request arriving in the same cycle as a `tlast` handshake is only arbitrated in the following `IDLE` cycle.
  - `i_rst` overrides every other event.

## Test plan

- **Single source, 3-byte packet:** src0 sends 0x41,0x42,0x43 with `tlast` on 0x43 and `i_tready`=1. Required: `o_tvalid` rises 1 cycle after the request, bytes appear in order, then `o_busy`=0 and `o_pkt_cnt`=1.
- **Contention, NUM_SRC=3:** all sources hold 2-byte packets continuously. Required: grant order after reset is 0,1,2,0,1,2; no interleaving; one idle cycle between packets; `o_pkt_cnt`=6 after six packets.
- **Backpressure:** `i_tready` toggles 1,0,0,1 during src1's 4-byte packet while src0 also requests. Required: bytes are never duplicated or dropped, `o_tready[0]` stays 0, and the grant moves to src0 only after src1's `tlast` handshake.
- **Single-beat packets:** src0 and src1 each send one-byte packets with `tlast`=1. Required: packets alternate 0,1,0,1 with a 2-cycle period.
- **Reset mid-packet:** assert `i_rst` for one cycle after byte 2 of 4 from src1. Required: all outputs are 0 the next cycle, `o_pkt_cnt` is unchanged at 0, and the next arbitration selects src0 first.
- **Counter wrap, CNT_W=4:** send 17 one-beat packets. Required: `o_pkt_cnt` reads 15 after 15 packets, 0 after 16, and 1 after 17.
